taxi_mac_pause_wm_ctrl: RTL and testbench

Watermark-driven pause request scheduler that sits between the RX buffer occupancy monitors and the MAC pause/PFC transmit control block. It watches per-priority fill levels, and drives that block's `tx_pfc_req`/`tx_lfc_req` and resend inputs. It applies XOFF/XON hysteresis, a minimum assertion hold time, and an emergency re-XOFF resend on critical fill. One instance serves one MAC port and supports either per-priority PFC or aggregate LFC.

---
 rtl/taxi_mac_pause_wm_ctrl_if.sv | 32 +++
 rtl/taxi_mac_pause_wm_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_taxi_mac_pause_wm_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/taxi_mac_pause_wm_ctrl_if.sv
// -----------------------------------------------------------------------------
// taxi_mac_pause_wm_ctrl_if
// Bundle of pause request signals between the watermark scheduler (master)
// and the MAC pause/PFC transmit control block (slave).
//   tx_pfc_req     8  per-priority pause request level
//   tx_pfc_resend  1  one-cycle PFC resend pulse
//   tx_lfc_req     1  link pause request level
//   tx_lfc_resend  1  one-cycle LFC resend pulse
// -----------------------------------------------------------------------------
interface taxi_mac_pause_wm_ctrl_if;

   logic [7:0] tx_pfc_req;
   logic       tx_pfc_resend;
   logic       tx_lfc_req;
   logic       tx_lfc_resend;

   // The scheduler drives the requests; the transmit control block consumes them
   modport master (
      output tx_pfc_req,
      output tx_pfc_resend,
      output tx_lfc_req,
      output tx_lfc_resend
   );

   modport slave (
      input tx_pfc_req,
      input tx_pfc_resend,
      input tx_lfc_req,
      input tx_lfc_resend
   );

endinterface

// File: rtl/taxi_mac_pause_wm_ctrl.sv
// -----------------------------------------------------------------------------
// taxi_mac_pause_wm_ctrl
// Watermark-driven pause request scheduler. Watches per-priority RX buffer fill
// levels and drives the MAC pause/PFC transmit control requests with XOFF/XON
// hysteresis, a minimum XOFF hold time and a re-XOFF resend on critical fill.
// Eight PFC channels run on the individual levels, one LFC channel runs on the
// aggregate of all eight levels (one pipeline stage later).
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   fill_lvl              8 x FILL_W per-priority occupancy, priority k at
//                         [k*FILL_W +: FILL_W]
//   cfg_en                global enable (0 forces every channel to XON)
//   cfg_pfc_mode          1 = PFC (8 channels), 0 = LFC (aggregate channel)
//   cfg_pfc_*_thr         per-priority XOFF/XON/critical thresholds
//   cfg_lfc_*_thr         aggregate XOFF/XON/critical thresholds (FILL_W+3)
//   cfg_min_hold          minimum cycles in XOFF_HOLD after XOFF entry
//   tx_pause              pause request interface (master side)
//   stat_xoff_evt         one-cycle pulse per XOFF entry, [7:0] PFC, [8] LFC
//   stat_xon_evt          one-cycle pulse per XOFF exit, same mapping
// -----------------------------------------------------------------------------
module taxi_mac_pause_wm_ctrl #(
   parameter int FILL_W = 16,
   parameter int HOLD_W = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [8*FILL_W-1:0]      fill_lvl,
   input  logic                     cfg_en,
   input  logic                     cfg_pfc_mode,
   input  logic [FILL_W-1:0]        cfg_pfc_xoff_thr,
   input  logic [FILL_W-1:0]        cfg_pfc_xon_thr,
   input  logic [FILL_W-1:0]        cfg_pfc_crit_thr,
   input  logic [FILL_W+2:0]        cfg_lfc_xoff_thr,
   input  logic [FILL_W+2:0]        cfg_lfc_xon_thr,
   input  logic [FILL_W+2:0]        cfg_lfc_crit_thr,
   input  logic [HOLD_W-1:0]        cfg_min_hold,
   taxi_mac_pause_wm_ctrl_if.master tx_pause,
   output logic [8:0]               stat_xoff_evt,
   output logic [8:0]               stat_xon_evt
);

   localparam int SUM_W = FILL_W + 3;
   localparam int NCH   = 9;
   localparam int LFC   = 8;

   typedef enum logic [1:0] {
      ST_XON       = 2'd0,
      ST_XOFF_HOLD = 2'd1,
      ST_XOFF      = 2'd2
   } chan_state_e;

   logic [FILL_W-1:0] lvl_q [8];
   logic [SUM_W-1:0]  sum_q, sum_d;

   chan_state_e       state_q [NCH];
   chan_state_e       state_d [NCH];
   logic [HOLD_W-1:0] cnt_q   [NCH];
   logic [HOLD_W-1:0] cnt_d   [NCH];
   logic [SUM_W-1:0]  prev_q  [NCH];

   logic [SUM_W-1:0]  chLvl   [NCH];
   logic [SUM_W-1:0]  chXoff  [NCH];
   logic [SUM_W-1:0]  chXon   [NCH];
   logic [SUM_W-1:0]  chCrit  [NCH];
   logic [NCH-1:0]    chActive;
   logic [NCH-1:0]    chReq;

   logic [NCH-1:0]    xoffEvt_d, xoffEvt_q;
   logic [NCH-1:0]    xonEvt_d, xonEvt_q;
   logic [NCH-1:0]    resendTrig;
   logic              pfcResend_q, lfcResend_q;

   // Aggregate of the staged levels. Eight FILL_W values fit in FILL_W+3 bits,
   // so the zero-extended sum never wraps.
   always_comb begin
      sum_d = '0;
      for (int k = 0; k < 8; k++) begin
         sum_d = sum_d + SUM_W'(lvl_q[k]);
      end
   end

   // Stage 1 captures the raw levels, stage 2 the aggregate. The LFC channel
   // therefore sees its level one cycle after the PFC channels see theirs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 8; k++) begin
            lvl_q[k] <= '0;
         end
         sum_q <= '0;
      end else begin
         for (int k = 0; k < 8; k++) begin
            lvl_q[k] <= fill_lvl[k*FILL_W +: FILL_W];
         end
         sum_q <= sum_d;
      end
   end

   // Present all nine channels in one common shape: channels 0..7 are the PFC
   // priorities on zero-extended per-priority values, channel 8 is the LFC
   // aggregate. The two groups are mutually exclusive through cfg_pfc_mode.
   always_comb begin
      for (int k = 0; k < 8; k++) begin
         chLvl[k]    = SUM_W'(lvl_q[k]);
         chXoff[k]   = SUM_W'(cfg_pfc_xoff_thr);
         chXon[k]    = SUM_W'(cfg_pfc_xon_thr);
         chCrit[k]   = SUM_W'(cfg_pfc_crit_thr);
         chActive[k] = cfg_en && cfg_pfc_mode;
      end
      chLvl[LFC]    = sum_q;
      chXoff[LFC]   = cfg_lfc_xoff_thr;
      chXon[LFC]    = cfg_lfc_xon_thr;
      chCrit[LFC]   = cfg_lfc_crit_thr;
      chActive[LFC] = cfg_en && !cfg_pfc_mode;
   end

   // Channel next-state logic. An inactive channel is forced to XON silently,
   // which also makes a mode change win over a same-cycle XOFF crossing. The
   // hold counter only runs in XOFF_HOLD, so the level is ignored there; a
   // counter of 1 (or a stray 0) moves the channel on to XOFF. Resend only
   // fires from an already-paused state, never on the entry cycle.
   always_comb begin
      for (int ch = 0; ch < NCH; ch++) begin
         state_d[ch]    = state_q[ch];
         cnt_d[ch]      = cnt_q[ch];
         xoffEvt_d[ch]  = 1'b0;
         xonEvt_d[ch]   = 1'b0;
         resendTrig[ch] = 1'b0;
         if (!chActive[ch]) begin
            state_d[ch] = ST_XON;
            cnt_d[ch]   = '0;
         end else begin
            resendTrig[ch] = (state_q[ch] != ST_XON) &&
                             (chLvl[ch] >= chCrit[ch]) &&
                             (prev_q[ch] < chCrit[ch]);
            case (state_q[ch])
               ST_XON: begin
                  if (chLvl[ch] >= chXoff[ch]) begin
                     xoffEvt_d[ch] = 1'b1;
                     if (cfg_min_hold == '0) begin
                        state_d[ch] = ST_XOFF;
                        cnt_d[ch]   = '0;
                     end else begin
                        state_d[ch] = ST_XOFF_HOLD;
                        cnt_d[ch]   = cfg_min_hold;
                     end
                  end
               end
               ST_XOFF_HOLD: begin
                  if (cnt_q[ch] <= HOLD_W'(1)) begin
                     state_d[ch] = ST_XOFF;
                     cnt_d[ch]   = '0;
                  end else begin
                     cnt_d[ch] = cnt_q[ch] - HOLD_W'(1);
                  end
               end
               ST_XOFF: begin
                  if (chLvl[ch] <= chXon[ch]) begin
                     state_d[ch]  = ST_XON;
                     xonEvt_d[ch] = 1'b1;
                  end
               end
               default: begin
                  state_d[ch] = ST_XON;
                  cnt_d[ch]   = '0;
               end
            endcase
         end
      end
   end

   // Channel state, hold counters, previous-level history and the registered
   // event/resend pulses. Everything clears on reset, so req drops at once and
   // no XON event is reported for a reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int ch = 0; ch < NCH; ch++) begin
            state_q[ch] <= ST_XON;
            cnt_q[ch]   <= '0;
            prev_q[ch]  <= '0;
         end
         xoffEvt_q   <= '0;
         xonEvt_q    <= '0;
         pfcResend_q <= 1'b0;
         lfcResend_q <= 1'b0;
      end else begin
         for (int ch = 0; ch < NCH; ch++) begin
            state_q[ch] <= state_d[ch];
            cnt_q[ch]   <= cnt_d[ch];
            prev_q[ch]  <= chLvl[ch];
         end
         xoffEvt_q   <= xoffEvt_d;
         xonEvt_q    <= xonEvt_d;
         pfcResend_q <= |resendTrig[7:0];
         lfcResend_q <= resendTrig[LFC];
      end
   end

   // A channel requests pause in both XOFF_HOLD and XOFF.
   always_comb begin
      for (int ch = 0; ch < NCH; ch++) begin
         chReq[ch] = (state_q[ch] != ST_XON);
      end
   end

   assign tx_pause.tx_pfc_req    = chReq[7:0];
   assign tx_pause.tx_lfc_req    = chReq[LFC];
   assign tx_pause.tx_pfc_resend = pfcResend_q;
   assign tx_pause.tx_lfc_resend = lfcResend_q;
   assign stat_xoff_evt          = xoffEvt_q;
   assign stat_xon_evt           = xonEvt_q;

endmodule

// File: tb/tb_taxi_mac_pause_wm_ctrl.sv
// -----------------------------------------------------------------------------
// tb_taxi_mac_pause_wm_ctrl
// Scoreboard bench: the driver pushes the reference model's expected outputs
// for every clock edge, an independent monitor pops and compares them after
// the edge. The model tracks each channel as "paused since edge e, releasable
// from edge e+H+1" over a history of sampled fill vectors.
// -----------------------------------------------------------------------------
module tb_taxi_mac_pause_wm_ctrl;

   localparam int FILL_W = 16;
   localparam int HOLD_W = 16;
   localparam int SUM_W  = FILL_W + 3;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic [8*FILL_W-1:0] fill_lvl;
   logic                cfg_en;
   logic                cfg_pfc_mode;
   logic [FILL_W-1:0]   cfg_pfc_xoff_thr, cfg_pfc_xon_thr, cfg_pfc_crit_thr;
   logic [SUM_W-1:0]    cfg_lfc_xoff_thr, cfg_lfc_xon_thr, cfg_lfc_crit_thr;
   logic [HOLD_W-1:0]   cfg_min_hold;
   logic [8:0]          stat_xoff_evt, stat_xon_evt;

   taxi_mac_pause_wm_ctrl_if txPause();

   taxi_mac_pause_wm_ctrl #(.FILL_W(FILL_W), .HOLD_W(HOLD_W)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .fill_lvl         (fill_lvl),
      .cfg_en           (cfg_en),
      .cfg_pfc_mode     (cfg_pfc_mode),
      .cfg_pfc_xoff_thr (cfg_pfc_xoff_thr),
      .cfg_pfc_xon_thr  (cfg_pfc_xon_thr),
      .cfg_pfc_crit_thr (cfg_pfc_crit_thr),
      .cfg_lfc_xoff_thr (cfg_lfc_xoff_thr),
      .cfg_lfc_xon_thr  (cfg_lfc_xon_thr),
      .cfg_lfc_crit_thr (cfg_lfc_crit_thr),
      .cfg_min_hold     (cfg_min_hold),
      .tx_pause         (txPause),
      .stat_xoff_evt    (stat_xoff_evt),
      .stat_xon_evt     (stat_xon_evt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] pfcReq;
      logic       pfcResend;
      logic       lfcReq;
      logic       lfcResend;
      logic [8:0] xoffEvt;
      logic [8:0] xonEvt;
   } expect_t;

   expect_t expQ[$];
   int      checks = 0;
   int      errors = 0;
   bit      monEn  = 1'b0;

   // Reference model state: the last three sampled fill vectors (index 0 is
   // the most recent), per-channel pause flag and earliest release edge.
   int unsigned fillHist [3][8];
   bit          paused [9];
   longint      releaseAt [9];
   longint      edgeNum = 0;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic modelReset();
      for (int h = 0; h < 3; h++)
         for (int k = 0; k < 8; k++)
            fillHist[h][k] = 0;
      for (int ch = 0; ch < 9; ch++) begin
         paused[ch]    = 1'b0;
         releaseAt[ch] = 0;
      end
   endtask

   // Expected outputs right after the coming edge, given the fill vector that
   // edge samples and the configuration currently applied.
   task automatic modelStep(input int unsigned lv [8], output expect_t e);
      int unsigned lvl, prev, xoffT, xonT, critT;
      bit          act, resend;
      e = '0;
      edgeNum++;
      for (int ch = 0; ch < 9; ch++) begin
         if (ch < 8) begin
            lvl   = fillHist[0][ch];
            prev  = fillHist[1][ch];
            xoffT = cfg_pfc_xoff_thr;
            xonT  = cfg_pfc_xon_thr;
            critT = cfg_pfc_crit_thr;
            act   = cfg_en && cfg_pfc_mode;
         end else begin
            lvl  = 0;
            prev = 0;
            for (int k = 0; k < 8; k++) begin
               lvl  += fillHist[1][k];
               prev += fillHist[2][k];
            end
            xoffT = cfg_lfc_xoff_thr;
            xonT  = cfg_lfc_xon_thr;
            critT = cfg_lfc_crit_thr;
            act   = cfg_en && !cfg_pfc_mode;
         end
         resend = 1'b0;
         if (!act) begin
            paused[ch] = 1'b0;
         end else if (!paused[ch]) begin
            if (lvl >= xoffT) begin
               paused[ch]     = 1'b1;
               releaseAt[ch]  = edgeNum + longint'(cfg_min_hold) + 1;
               e.xoffEvt[ch]  = 1'b1;
            end
         end else begin
            resend = (lvl >= critT) && (prev < critT);
            if (edgeNum >= releaseAt[ch] && lvl <= xonT) begin
               paused[ch]   = 1'b0;
               e.xonEvt[ch] = 1'b1;
            end
         end
         if (ch < 8) begin
            e.pfcReq[ch] = paused[ch];
            if (resend) e.pfcResend = 1'b1;
         end else begin
            e.lfcReq    = paused[ch];
            e.lfcResend = resend;
         end
      end
      for (int k = 0; k < 8; k++) begin
         fillHist[2][k] = fillHist[1][k];
         fillHist[1][k] = fillHist[0][k];
         fillHist[0][k] = lv[k];
      end
   endtask

   // Called at a falling edge: drive levels, queue the expectation for the
   // next rising edge, and return at the following falling edge.
   task automatic applyStimulus(input int unsigned lv [8]);
      expect_t e;
      for (int k = 0; k < 8; k++)
         fill_lvl[k*FILL_W +: FILL_W] = FILL_W'(lv[k]);
      modelStep(lv, e);
      expQ.push_back(e);
      @(negedge clk);
   endtask

   // Monitor: one expectation per rising edge while enabled.
   initial begin
      expect_t e;
      forever begin
         @(posedge clk);
         #1;
         if (monEn) begin
            if (expQ.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL scoreboard_empty: got no expectation, required one at %0t", $time);
            end else begin
               e = expQ.pop_front();
               checkOutput("tx_pfc_req",    32'(txPause.tx_pfc_req),    32'(e.pfcReq));
               checkOutput("tx_pfc_resend", 32'(txPause.tx_pfc_resend), 32'(e.pfcResend));
               checkOutput("tx_lfc_req",    32'(txPause.tx_lfc_req),    32'(e.lfcReq));
               checkOutput("tx_lfc_resend", 32'(txPause.tx_lfc_resend), 32'(e.lfcResend));
               checkOutput("stat_xoff_evt", 32'(stat_xoff_evt),         32'(e.xoffEvt));
               checkOutput("stat_xon_evt",  32'(stat_xon_evt),          32'(e.xonEvt));
            end
         end
      end
   end

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_pfc_req"},    32'(txPause.tx_pfc_req),    32'd0);
      checkOutput({tag, "_pfc_resend"}, 32'(txPause.tx_pfc_resend), 32'd0);
      checkOutput({tag, "_lfc_req"},    32'(txPause.tx_lfc_req),    32'd0);
      checkOutput({tag, "_lfc_resend"}, 32'(txPause.tx_lfc_resend), 32'd0);
      checkOutput({tag, "_xoff_evt"},   32'(stat_xoff_evt),         32'd0);
      checkOutput({tag, "_xon_evt"},    32'(stat_xon_evt),          32'd0);
   endtask

   initial begin
      int unsigned lv [8];
      lv               = '{default: 0};
      fill_lvl         = '0;
      cfg_en           = 1'b1;
      cfg_pfc_mode     = 1'b1;
      cfg_pfc_xoff_thr = 16'd1000;
      cfg_pfc_xon_thr  = 16'd200;
      cfg_pfc_crit_thr = 16'd60000;
      cfg_lfc_xoff_thr = 19'd4000;
      cfg_lfc_xon_thr  = 19'd1000;
      cfg_lfc_crit_thr = 19'd100000;
      cfg_min_hold     = '0;
      modelReset();

      repeat (3) @(negedge clk);
      checkAllZero("reset");
      rst_n = 1'b1;
      monEn = 1'b1;

      // PFC hysteresis on priority 3
      foreach (lv[i]) lv[i] = 0;
      for (int s = 0; s <= 4; s++) begin
         lv[3] = s * 250;
         applyStimulus(lv);
      end
      repeat (4) applyStimulus(lv);
      lv[3] = 500;
      repeat (4) applyStimulus(lv);
      lv[3] = 200;
      repeat (4) applyStimulus(lv);
      lv[3] = 0;
      repeat (2) applyStimulus(lv);

      // Minimum hold: one sample above XOFF, then empty
      cfg_min_hold = 16'd10;
      lv[3] = 1200;
      applyStimulus(lv);
      lv[3] = 0;
      repeat (16) applyStimulus(lv);

      // LFC aggregate just below and then exactly at XOFF
      cfg_pfc_mode = 1'b0;
      cfg_min_hold = 16'd0;
      foreach (lv[i]) lv[i] = 499;
      repeat (6) applyStimulus(lv);
      lv[0] = 507;
      repeat (6) applyStimulus(lv);
      foreach (lv[i]) lv[i] = 0;
      repeat (6) applyStimulus(lv);

      // Critical resend on priorities 1 and 5 crossing together
      cfg_pfc_mode     = 1'b1;
      cfg_pfc_crit_thr = 16'd3000;
      cfg_min_hold     = 16'd2;
      lv[1] = 2999;
      lv[5] = 2999;
      repeat (6) applyStimulus(lv);
      lv[1] = 3000;
      lv[5] = 3000;
      repeat (5) applyStimulus(lv);
      lv[1] = 0;
      lv[5] = 0;
      repeat (8) applyStimulus(lv);

      // Mode switch while 0x0F is paused, then global disable
      cfg_min_hold = 16'd0;
      for (int k = 0; k < 4; k++) lv[k] = 1500;
      repeat (4) applyStimulus(lv);
      cfg_pfc_mode = 1'b0;
      repeat (6) applyStimulus(lv);
      cfg_en = 1'b0;
      repeat (3) applyStimulus(lv);
      cfg_en       = 1'b1;
      cfg_pfc_mode = 1'b1;
      foreach (lv[i]) lv[i] = 0;
      repeat (4) applyStimulus(lv);

      // Asynchronous reset between edges while priority 2 is paused
      lv[2] = 1500;
      repeat (4) applyStimulus(lv);
      checkOutput("pre_reset_req2", 32'(txPause.tx_pfc_req[2]), 32'd1);
      monEn = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      checkAllZero("async_reset");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      expQ.delete();
      modelReset();
      monEn = 1'b1;
      repeat (4) applyStimulus(lv);
      lv[2] = 0;
      repeat (3) applyStimulus(lv);

      // Randomised traffic around the thresholds with occasional config churn
      for (int c = 0; c < 3000; c++) begin
         if (c % 200 == 0) begin
            cfg_pfc_xoff_thr = 16'($urandom_range(400, 800));
            cfg_pfc_xon_thr  = 16'($urandom_range(100, 700));
            cfg_pfc_crit_thr = 16'($urandom_range(int'(cfg_pfc_xoff_thr), 1250));
            cfg_lfc_xoff_thr = 19'($urandom_range(3000, 6000));
            cfg_lfc_xon_thr  = 19'($urandom_range(1000, 4000));
            cfg_lfc_crit_thr = 19'($urandom_range(3000, 8000));
            cfg_min_hold     = 16'($urandom_range(0, 5));
         end
         if ($urandom_range(0, 49) == 0) cfg_pfc_mode = ~cfg_pfc_mode;
         cfg_en = ($urandom_range(0, 99) != 0);
         for (int k = 0; k < 8; k++)
            if ($urandom_range(0, 3) == 0) lv[k] = $urandom_range(0, 1300);
         applyStimulus(lv);
      end
      monEn = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
